dmem_access_unit: RTL

- Initiator side of the data-memory path. Accepts one load/store request at a time from the CPU MEM stage and drives the data memory manager's address, data, write-enable and byte-mode inputs.
- Issues halfword stores as two sequential byte writes. Handles the synchronous read latency of the banked RAM.
- Returns load data lane-extracted and sign- or zero-extended, with a single-cycle response pulse.
- Sits between the pipeline MEM stage and the bank-decoding data memory manager. Bank selection by address bits [19:18] stays in the manager.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/load_extract.sv | 26 ++
 rtl/dmem_access_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access unit.
// Covers request sizes, memory-manager byte-mode codes and FSM states.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        ST_ISSUE,
        ST_HI,
        LD_ADDR,
        LD_WAIT,
        RESP
    } state_t;

    localparam logic [31:0] BM_WORD = 32'd0;
    localparam logic [31:0] BM_BYTE = 32'd1;

    // A request is bad if it is misaligned for its size or uses the reserved size.
    function automatic logic req_is_bad(input size_t size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: req_is_bad = 1'b0;
            SZ_HALF: req_is_bad = lo[0];
            SZ_WORD: req_is_bad = (lo != 2'b00);
            default: req_is_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Little-endian lane selection plus sign/zero extension of a read word.
// Purely combinational; the caller supplies the low address bits and size.
module load_extract
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  size_t       i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage initiator for the banked data memory: one request at a time,
// halfword stores split into two byte writes, loads wait out the RAM latency.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [31:0]       mem_data_o,
    output logic              mem_wren_o,
    output logic [31:0]       mem_byte_mode_o,
    input  logic [31:0]       mem_data_i
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    size_t             r_size;
    logic              r_signed;
    logic [1:0]        r_lat_cnt;
    logic [31:0]       w_ld_data;
    size_t             w_req_size;

    assign req_ready_o = (r_state == IDLE);
    assign w_req_size  = size_t'(req_size_i);

    load_extract u_extract (
        .i_word   (mem_data_i),
        .i_lane   (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_ld_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_size          <= SZ_BYTE;
            r_signed        <= 1'b0;
            r_lat_cnt       <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_rdata_o     <= '0;
            rsp_err_o       <= 1'b0;
            mem_address_o   <= '0;
            mem_data_o      <= '0;
            mem_wren_o      <= 1'b0;
            mem_byte_mode_o <= BM_WORD;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_addr   <= req_addr_i;
                        r_wdata  <= req_wdata_i;
                        r_size   <= w_req_size;
                        r_signed <= req_signed_i;
                        if (req_is_bad(w_req_size, req_addr_i[1:0])) begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                            r_state     <= RESP;
                        end else if (req_we_i) begin
                            mem_wren_o    <= 1'b1;
                            mem_address_o <= req_addr_i;
                            if (w_req_size == SZ_WORD) begin
                                mem_data_o      <= req_wdata_i;
                                mem_byte_mode_o <= BM_WORD;
                            end else begin
                                mem_data_o      <= {24'b0, req_wdata_i[7:0]};
                                mem_byte_mode_o <= BM_BYTE;
                            end
                            r_state <= ST_ISSUE;
                        end else begin
                            mem_address_o   <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            mem_byte_mode_o <= BM_WORD;
                            r_state         <= LD_ADDR;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_size == SZ_HALF) begin
                        // Half-aligned, so +1 never leaves the word or the bank.
                        mem_address_o <= r_addr + ADDR_W'(1);
                        mem_data_o    <= {24'b0, r_wdata[15:8]};
                        r_state       <= ST_HI;
                    end else begin
                        mem_wren_o  <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= '0;
                        r_state     <= RESP;
                    end
                end
                ST_HI: begin
                    mem_wren_o  <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                    r_state     <= RESP;
                end
                LD_ADDR: begin
                    r_lat_cnt <= 2'(READ_LATENCY);
                    r_state   <= LD_WAIT;
                end
                LD_WAIT: begin
                    // Data is captured on the edge where the count reaches zero.
                    if (r_lat_cnt == 2'd1) begin
                        r_lat_cnt   <= '0;
                        rsp_rdata_o <= w_ld_data;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        r_state     <= RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    rsp_valid_o <= 1'b0;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
